// File: rtl/uart_rx.sv
// 8N1-style UART receiver with 16x oversampling, 2-flop input synchronizer and
// one-cycle strobes for a good byte (o_valid) or a low stop bit (o_frame_error).
module uart_rx #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned DIVISOR = 163
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_frame_error
);

  localparam int unsigned TW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int unsigned NW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam int unsigned SW = 4;

  localparam logic [TW-1:0] TICK_MAX = TW'(DIVISOR - 1);
  localparam logic [SW-1:0] S_MID    = SW'(7);
  localparam logic [SW-1:0] S_END    = SW'(15);
  localparam logic [SW-1:0] S_STOP   = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST   = NW'(NB_DATA - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic               rx_meta;
  logic               rx_s;
  logic [TW-1:0]      div_q;
  logic               tick;

  state_t             state_q, state_d;
  logic [SW-1:0]      s_q, s_d;
  logic [NW-1:0]      n_q, n_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;

  // Line is idle high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // Free-running oversampling tick generator.
  assign tick = (div_q == TICK_MAX);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + TW'(1);
    end
  end

  // Frame state and output registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          s_d     = '0;
          state_d = START;
        end
      end

      // Re-check the line at mid start bit; a high here was a glitch.
      START: begin
        if (tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              s_d     = '0;
              n_d     = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (s_q == S_END) begin
            s_d = '0;
            b_d = {rx_s, b_q[NB_DATA-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (s_q == S_STOP) begin
            state_d = IDLE;
            if (rx_s) begin
              data_d  = b_q;
              valid_d = 1'b1;
            end else begin
              ferr_d  = 1'b1;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign o_data        = data_q;
  assign o_valid       = valid_q;
  assign o_frame_error = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and random serial frames compared against a
// frame-level model of the expected strobe sequence.
module tb_uart_rx;

  localparam int unsigned DIV  = 4;
  localparam int unsigned BIT  = DIV * 16;
  localparam int unsigned FRAME = BIT * 10;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ferr;

  typedef struct packed {
    logic        is_err;
    logic [7:0]  data;
    logic [31:0] cyc;
  } ev_t;

  ev_t         obs_q[$];
  ev_t         exp_q[$];
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_fail;
  int unsigned both_hi;
  logic [7:0]  last_data;

  uart_rx #(
    .NB_DATA (8),
    .SB_TICK (16),
    .DIVISOR (DIV)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_rx          (rx),
    .o_data        (data),
    .o_valid       (valid),
    .o_frame_error (ferr)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Each high cycle of a strobe is logged separately, so a stretched pulse shows up as extras.
  always @(negedge clk) begin
    if (valid || ferr) obs_q.push_back('{is_err: ferr, data: data, cyc: cyc});
    if (valid && ferr) both_hi++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  // A bad stop bit is held low only past its mid-bit sample, so its tail
  // cannot be mistaken for a new start bit.
  task automatic send(input logic [7:0] d, input bit bad_stop, output int unsigned edge_cyc);
    edge_cyc = cyc;
    if (bad_stop) exp_q.push_back('{is_err: 1'b1, data: last_data, cyc: 0});
    else begin
      exp_q.push_back('{is_err: 1'b0, data: d, cyc: 0});
      last_data = d;
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (bad_stop) begin
      rx = 1'b0;
      repeat (40) @(negedge clk);
      rx = 1'b1;
      repeat (BIT - 40) @(negedge clk);
    end else begin
      drive_bit(1'b1);
    end
  endtask

  task automatic glitch(input int unsigned len);
    rx = 1'b0;
    repeat (len) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic drain(input string tag);
    int unsigned n;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < int'(n); i++) begin
      check({tag, "_kind"}, 32'(obs_q[i].is_err), 32'(exp_q[i].is_err));
      check({tag, "_data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int unsigned e0, e1, lat;
    logic [7:0]  d;
    bit          bad;

    cyc = 0; n_checks = 0; n_fail = 0; both_hi = 0; last_data = 8'h00;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (50) @(negedge clk);
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_ferr", 32'(ferr), 32'h0);
    rst = 1'b0;
    idle(20);

    // Single 0xFF frame plus start-edge-to-strobe latency.
    send(8'hFF, 1'b0, e0);
    idle(100);
    lat = (obs_q.size() > 0) ? obs_q[0].cyc - e0 : 0;
    check("latency_ok", 32'(lat >= 608 && lat <= 611), 32'h1);
    drain("ff");

    // Back-to-back frames, strobes exactly one frame apart.
    send(8'h01, 1'b0, e0);
    send(8'h20, 1'b0, e1);
    idle(100);
    if (obs_q.size() >= 2) check("b2b_spacing", obs_q[1].cyc - obs_q[0].cyc, FRAME);
    drain("b2b");

    // Short low pulse on the idle line.
    glitch(12);
    idle(300);
    drain("glitch");

    // Bad stop bit: error strobe, o_data keeps 0x20.
    send(8'h55, 1'b1, e0);
    idle(100);
    check("ferr_hold_data", 32'(data), 32'h20);
    drain("ferr");

    // Reset during bit 4 of 0xA5, then a clean 0x3C.
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_bit(d_a5(i));
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_data", 32'(data), 32'h0);
    rx  = 1'b1;
    rst = 1'b0;
    last_data = 8'h00;
    idle(300);
    drain("midrst");
    send(8'h3C, 1'b0, e0);
    idle(100);
    drain("after_rst");

    // Random frames, bad stops, glitches and gaps.
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 99) < 15) begin
        glitch($urandom_range(1, 20));
        idle($urandom_range(60, 120));
      end
      d   = 8'($urandom);
      bad = ($urandom_range(0, 99) < 20);
      send(d, bad, e0);
      idle($urandom_range(0, 80));
    end
    idle(100);
    drain("random");

    // Break: line low for three frame times gives three errors, no valid.
    rx = 1'b0;
    repeat (3 * FRAME) @(negedge clk);
    for (int i = 0; i < 3; i++) exp_q.push_back('{is_err: 1'b1, data: last_data, cyc: 0});
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    last_data = 8'h00;
    idle(100);
    drain("break");

    check("never_both", both_hi, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic d_a5(input int i);
    logic [7:0] v;
    v = 8'hA5;
    return v[i];
  endfunction

endmodule
